// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Shares a single iterative GCD engine between NREQ requesters. A round-robin
// arbiter accepts one request at a time and latches its operands. Zero-operand
// requests are answered directly, without starting the engine. All other
// requests start the engine and wait for done, with a timeout. The result (or a
// timeout error) is returned to the winning requester over a valid/ready
// handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (the engine shares it)
//   req_valid_i  per-requester request valid
//   req_ready_o  request accept strobe, one-hot or zero, asserted only in IDLE
//   req_a_i      operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b_i      operand b, same packing
//   rsp_valid_o  response valid, one-hot on the winning requester
//   rsp_ready_i  per-requester response accept
//   rsp_data_o   result bus shared by all requesters, qualified by rsp_valid_o
//   rsp_err_o    response is a timeout error (rsp_data_o is then 0)
//   eng_start_o  one-cycle engine start pulse
//   eng_a_o      latched operand a to the engine
//   eng_b_o      latched operand b to the engine
//   eng_done_i   engine result valid (a pulse or a level)
//   eng_result_i engine result
//   busy_o       high whenever a transaction is in flight
module gcd_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  eng_start_o,
  output logic [WIDTH-1:0]      eng_a_o,
  output logic [WIDTH-1:0]      eng_b_o,
  input  logic                  eng_done_i,
  input  logic [WIDTH-1:0]      eng_result_i,
  output logic                  busy_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(NREQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] win_a, win_b;

  // Round-robin pick: scan downward from the farthest candidate so that the
  // last hit is the first valid requester after last_grant_q.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end else begin
        win_found = win_found;
      end
    end
  end

  assign win_a = req_a_i[win_id*WIDTH +: WIDTH];
  assign win_b = req_b_i[win_id*WIDTH +: WIDTH];

  // The grant is combinational so a requester sees ready in the same IDLE cycle.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE && win_found) begin
      req_ready_o[win_id] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Response valid is decoded from the registered state and the captured id.
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == ST_RESP) begin
      rsp_valid_o[id_q] = 1'b1;
    end else begin
      rsp_valid_o = '0;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    err_d        = err_q;
    timer_d      = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          id_d = win_id;
          a_d  = win_a;
          b_d  = win_b;
          // gcd(x,0)=x and gcd(0,0)=0, so a|b is the answer without the engine.
          if (win_a == '0 || win_b == '0) begin
            data_d  = win_a | win_b;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last timer cycle still beats the timeout.
        if (eng_done_i) begin
          data_d  = eng_result_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i[id_q]) begin
          last_grant_d = id_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; the asynchronous reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_ID;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
    end
  end

  assign eng_start_o = (state_q == ST_ISSUE);
  assign eng_a_o     = a_q;
  assign eng_b_o     = b_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter. It includes a behavioural engine with a
// programmable latency, a hang mode and stray done pulses. A transaction-level
// model (round-robin pick, Euclid GCD, expected-response queue) is checked on
// every cycle, and directed tests pin the model with literal expectations.
module tb_gcd_arbiter;
  localparam int NREQ = 4, WIDTH = 5, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] rsp_data, eng_a, eng_b;
  logic [WIDTH-1:0] eng_result = '0;
  logic rsp_err, eng_start, busy;
  logic eng_done = 1'b0;

  always #5 clk = ~clk;

  gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .eng_start_o(eng_start), .eng_a_o(eng_a), .eng_b_o(eng_b),
    .eng_done_i(eng_done), .eng_result_i(eng_result),
    .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gcd(int x, int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Engine model: done comes eng_lat cycles after the start pulse; stray_req forces a bogus done.
  int eng_lat = 5;
  bit eng_hang = 1'b0;
  bit stray_req = 1'b0;
  int eng_cnt = 0;
  int ea = 0, eb = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt = 0;
      eng_done = 1'b0;
      eng_result = '0;
    end else begin
      eng_done = 1'b0;
      if (stray_req) begin
        eng_done = 1'b1;
        eng_result = 5'd31;
      end else if (eng_start && !eng_hang) begin
        eng_cnt = eng_lat;
        ea = int'(eng_a);
        eb = int'(eng_b);
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          eng_result = WIDTH'(gcd(ea, eb));
        end
      end
    end
  end

  typedef struct {int id; int a; int b; int data; int err; int byp; int started; int seen;} txn_t;
  txn_t exp_q[$];
  int grant_log[$];
  int model_last = NREQ - 1;
  int cyc = 0, rsp_count = 0, start_count = 0;
  int accept_cyc = 0, start_cyc = 0, rsp_first_cyc = 0;
  int start_a = 0, start_b = 0;
  int last_id = 0, last_data = 0, last_err = 0;

  // Compare process: model vs DUT outputs every cycle, sampled at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_last = NREQ - 1;
    end else begin
      int exp_busy;
      int pick;
      txn_t h;
      cyc++;
      exp_busy = (exp_q.size() != 0) ? 1 : 0;
      chk("busy", int'(busy), exp_busy);
      chk("req_ready_onehot", int'($countones(req_ready) <= 1), 1);
      pick = rr_pick(model_last, req_valid);
      if (exp_busy != 0) chk("req_ready_busy", int'(req_ready), 0);
      else chk("req_ready_grant", int'(req_ready), (pick < 0) ? 0 : (1 << pick));

      if (eng_start) begin
        start_count++;
        start_cyc = cyc;
        start_a = int'(eng_a);
        start_b = int'(eng_b);
        chk("eng_start_txn", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          chk("eng_start_bypass", exp_q[0].byp, 0);
          chk("eng_start_once", exp_q[0].started, 0);
          exp_q[0].started = 1;
        end
      end
      if (exp_q.size() > 0 && exp_q[0].started != 0) begin
        chk("eng_a", int'(eng_a), exp_q[0].a);
        chk("eng_b", int'(eng_b), exp_q[0].b);
      end

      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", int'(rsp_valid), 0);
        end else begin
          h = exp_q[0];
          chk("rsp_valid_id", int'(rsp_valid), 1 << h.id);
          chk("rsp_data", int'(rsp_data), h.data);
          chk("rsp_err", int'(rsp_err), h.err);
          if (h.byp == 0) chk("rsp_after_start", h.started, 1);
          if (h.seen == 0) begin
            exp_q[0].seen = 1;
            rsp_first_cyc = cyc;
          end
          if (rsp_ready[h.id]) begin
            void'(exp_q.pop_front());
            model_last = h.id;
            rsp_count++;
            last_id = h.id;
            last_data = int'(rsp_data);
            last_err = int'(rsp_err);
            grant_log.push_back(h.id);
          end
        end
      end

      if (exp_busy == 0 && pick >= 0 && req_ready[pick]) begin
        txn_t t;
        t.id = pick;
        t.a = int'(req_a[pick*WIDTH +: WIDTH]);
        t.b = int'(req_b[pick*WIDTH +: WIDTH]);
        t.byp = (t.a == 0 || t.b == 0) ? 1 : 0;
        t.err = (t.byp == 0 && eng_hang) ? 1 : 0;
        t.data = (t.err != 0) ? 0 : gcd(t.a, t.b);
        t.started = 0;
        t.seen = 0;
        exp_q.push_back(t);
        accept_cyc = cyc;
      end
    end
  end

  task automatic submit(int id, int a, int b);
    int n;
    n = 0;
    req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
    req_valid[id] = 1'b1;
    @(negedge clk);
    while (!req_ready[id] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept", int'(req_ready[id]), 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_cnt(int target, string name);
    int n;
    n = 0;
    while (rsp_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(rsp_count >= target), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, int'(rsp_data), 0);
    chk({tag, "_rsp_err"}, int'(rsp_err), 0);
    chk({tag, "_eng_start"}, int'(eng_start), 0);
    chk({tag, "_eng_a"}, int'(eng_a), 0);
    chk({tag, "_eng_b"}, int'(eng_b), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int base, s0, g0;
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single request through the engine
    base = rsp_count; s0 = start_count;
    submit(0, 12, 18);
    wait_cnt(base + 1, "t1_done");
    chk("t1_data", last_data, 6);
    chk("t1_err", last_err, 0);
    chk("t1_id", last_id, 0);
    chk("t1_starts", start_count - s0, 1);
    chk("t1_eng_a", start_a, 12);
    chk("t1_eng_b", start_b, 18);

    // 3: zero-operand bypass
    base = rsp_count; s0 = start_count;
    submit(2, 0, 9);
    wait_cnt(base + 1, "t3_done");
    chk("t3_data", last_data, 9);
    chk("t3_id", last_id, 2);
    chk("t3_latency", rsp_first_cyc - accept_cyc, 1);
    submit(2, 0, 0);
    wait_cnt(base + 2, "t3b_done");
    chk("t3b_data", last_data, 0);
    chk("t3b_err", last_err, 0);
    submit(3, 7, 0);
    wait_cnt(base + 3, "t3c_done");
    chk("t3c_data", last_data, 7);
    chk("t3_no_start", start_count - s0, 0);

    // 4: engine hang -> timeout error, then normal service
    eng_hang = 1'b1;
    base = rsp_count;
    submit(0, 15, 10);
    wait_cnt(base + 1, "t4_done");
    chk("t4_err", last_err, 1);
    chk("t4_data", last_data, 0);
    chk("t4_wait_cycles", rsp_first_cyc - start_cyc, 65);
    eng_hang = 1'b0;
    submit(0, 15, 10);
    wait_cnt(base + 2, "t4b_done");
    chk("t4b_data", last_data, 5);
    chk("t4b_err", last_err, 0);

    // 5: response stall with stray done pulses
    rsp_ready = 4'b1101;
    base = rsp_count;
    submit(1, 21, 14);
    begin
      int n;
      n = 0;
      while (!rsp_valid[1] && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t5_rsp_seen", int'(rsp_valid[1]), 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      stray_req = (i == 3 || i == 6);
      @(negedge clk);
      chk("t5_hold_valid", int'(rsp_valid), 2);
      chk("t5_hold_data", int'(rsp_data), 7);
      chk("t5_hold_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    stray_req = 1'b0;
    chk("t5_no_pop", rsp_count, base);
    rsp_ready = '1;
    wait_cnt(base + 1, "t5_done");
    chk("t5_data", last_data, 7);
    stray_req = 1'b1;
    @(posedge clk); #1;
    stray_req = 1'b0;
    @(negedge clk);
    chk("t5_idle_stray", int'(busy), 0);
    @(posedge clk); #1;

    // 6: reset during WAIT
    eng_hang = 1'b1;
    s0 = start_count;
    submit(3, 9, 6);
    repeat (5) @(posedge clk);
    chk("t6_started", start_count - s0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(posedge clk); #3;
    rst_n = 1'b1;
    eng_hang = 1'b0;
    @(posedge clk); #1;

    // 2: all requesters valid continuously; arbitration restarts at 0
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 5'd20;
      req_b[i*WIDTH +: WIDTH] = 5'd8;
    end
    base = rsp_count;
    g0 = grant_log.size();
    rsp_ready = '1;
    req_valid = 4'hF;
    wait_cnt(base + 5, "t2_done");
    req_valid = '0;
    drain();
    for (int k = 0; k < 5; k++) begin
      chk("t2_grant", (grant_log.size() > g0 + k) ? grant_log[g0 + k] : -1, exp_g[k]);
    end
    chk("t2_data", last_data, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
